// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: bundles the PC, instruction-memory and decoder-queue
// handshakes of the fetch stage; master is the fetch unit, slave its environment.
interface instruction_fetch_if #(
    parameter int WORDSIZE = 64,
    parameter int INSTSIZE = 32
);
    logic [WORDSIZE-1:0] pc_addr;
    logic                pc_advance;
    logic                flush;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [WORDSIZE-1:0] mem_req_addr;
    logic                mem_resp_valid;
    logic [INSTSIZE-1:0] mem_resp_data;
    logic                mem_resp_error;
    logic                inst_valid;
    logic                inst_ready;
    logic [INSTSIZE-1:0] inst_data;
    logic [WORDSIZE-1:0] inst_addr;
    logic                inst_fault;
    modport master (
        input  pc_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error, inst_ready,
        output pc_advance, mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_addr, inst_fault
    );
    modport slave (
        output pc_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error, inst_ready,
        input  pc_advance, mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_addr, inst_fault
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch with a small tagged
// instruction queue, misalignment/access-fault entries and flush handling.
module instruction_fetch #(
    parameter int WORDSIZE = 64,
    parameter int INSTSIZE = 32,
    parameter int DEPTH    = 2
) (
    input logic               clk,
    input logic               rst_n,
    instruction_fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2, DRAIN = 3'd3, FAULT = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [WORDSIZE-1:0] req_addr_q, req_addr_d;
    logic [AW-1:0]       head_q, tail_q;
    logic [AW:0]         count_q;
    logic [INSTSIZE-1:0] data_q [DEPTH];
    logic [WORDSIZE-1:0] addr_q [DEPTH];
    logic [DEPTH-1:0]    fault_q;
    logic                push, pop, push_fault;
    logic [INSTSIZE-1:0] push_data;
    logic [WORDSIZE-1:0] push_addr;

    always_comb begin
        state_d            = state_q;
        req_addr_d         = req_addr_q;
        push               = 1'b0;
        push_data          = bus.mem_resp_data;
        push_addr          = req_addr_q;
        push_fault         = bus.mem_resp_error;
        bus.mem_req_valid  = 1'b0;
        bus.pc_advance     = 1'b0;
        case (state_q)
            IDLE: if (!bus.flush && count_q != FULL) begin
                if (bus.pc_addr[1:0] == 2'b00) begin
                    req_addr_d = bus.pc_addr;
                    state_d    = REQ;
                end else begin
                    push       = 1'b1;
                    push_data  = '0;
                    push_addr  = bus.pc_addr;
                    push_fault = 1'b1;
                    state_d    = FAULT;
                end
            end
            REQ: begin
                // a flush withdraws the request so memory never sees a handshake
                bus.mem_req_valid = !bus.flush;
                bus.pc_advance    = bus.mem_req_ready && !bus.flush;
                state_d           = bus.flush ? IDLE : bus.mem_req_ready ? WAIT : REQ;
            end
            WAIT: begin
                push    = bus.mem_resp_valid && !bus.flush;
                state_d = bus.mem_resp_valid ? ((bus.mem_resp_error && !bus.flush) ? FAULT : IDLE)
                        : bus.flush ? DRAIN : WAIT;
            end
            DRAIN: state_d = bus.mem_resp_valid ? IDLE : DRAIN;
            FAULT: state_d = bus.flush ? IDLE : FAULT;
            default: state_d = IDLE;
        endcase
    end

    assign pop              = bus.inst_valid && bus.inst_ready;
    assign bus.inst_valid   = count_q != '0;
    assign bus.inst_data    = data_q[head_q];
    assign bus.inst_addr    = addr_q[head_q];
    assign bus.inst_fault   = fault_q[head_q];
    assign bus.mem_req_addr = req_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fault_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            if (bus.flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    data_q[tail_q]  <= push_data;
                    addr_q[tail_q]  <= push_addr;
                    fault_q[tail_q] <= push_fault;
                    tail_q          <= tail_q + 1'b1;
                end
                if (pop) head_q <= head_q + 1'b1;
                count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus around a queue-level model of the fetch
// stage, with a bench-side program counter and instruction memory.
module tb_instruction_fetch;
    localparam int W = 64, I = 32, DEPTH = 2;

    typedef struct {
        logic [I-1:0] data;
        logic [W-1:0] addr;
        logic         fault;
    } ent_t;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if #(.WORDSIZE(W), .INSTSIZE(I)) bus ();
    instruction_fetch #(.WORDSIZE(W), .INSTSIZE(I), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0, fails = 0;
    int resp_delay = 1, cnt = 0;
    ent_t q[$];
    ent_t e;
    logic [W-1:0] pc_model = '0, flush_tgt = '0, out_addr = '0, c_addr = '0, rsp_addr = '0;
    logic outstanding = 0, stale = 0, faulted = 0, exp_fault = 0;
    logic c_hs = 0, c_adv = 0, c_flush = 0;

    assign bus.pc_addr = pc_model;

    // memory map of the bench: data derived from address, access error at 0x2000
    function automatic logic [I-1:0] data_of(input logic [W-1:0] a);
        return (a == 64'h3000) ? 32'hDEADBEEF : {a[15:0], 16'h0013};
    endfunction

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_req_valid"}, bus.mem_req_valid, 0);
        chk({n, "_pc_adv"}, bus.pc_advance, 0);
        chk({n, "_req_addr"}, bus.mem_req_addr, 0);
        chk({n, "_inst_valid"}, bus.inst_valid, 0);
        chk({n, "_inst_data"}, bus.inst_data, 0);
        chk({n, "_inst_addr"}, bus.inst_addr, 0);
        chk({n, "_inst_fault"}, bus.inst_fault, 0);
    endtask

    // program counter and memory responder: react to what the last edge consumed
    initial begin
        bus.mem_resp_valid = 0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_error = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_resp_valid = 0;
            bus.mem_resp_data  = '0;
            bus.mem_resp_error = 0;
            if (!rst_n) begin
                cnt      = 0;
                pc_model = '0;
            end else begin
                if (c_flush) pc_model = flush_tgt;
                else if (c_adv) pc_model = pc_model + 64'd4;
                if (c_hs) begin
                    cnt      = resp_delay;
                    rsp_addr = c_addr;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.mem_resp_valid = 1;
                        bus.mem_resp_data  = data_of(rsp_addr);
                        bus.mem_resp_error = (rsp_addr == 64'h2000);
                    end
                end
            end
        end
    end

    // compare DUT against the model, then advance the model with the inputs of the coming edge
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            outstanding = 0;
            stale       = 0;
            faulted     = 0;
            c_hs        = 0;
            c_adv       = 0;
            c_flush     = 0;
        end else begin
            chk("inst_valid", bus.inst_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("inst_data", bus.inst_data, q[0].data);
                chk("inst_addr", bus.inst_addr, q[0].addr);
                chk("inst_fault", bus.inst_fault, q[0].fault);
            end
            chk("pc_advance", bus.pc_advance, bus.mem_req_valid && bus.mem_req_ready);
            if (bus.mem_req_valid) chk("mem_req_addr", bus.mem_req_addr, pc_model);
            if (faulted || outstanding || q.size() == DEPTH) chk("req_blocked", bus.mem_req_valid, 0);
            c_hs    = bus.mem_req_valid && bus.mem_req_ready;
            c_adv   = bus.pc_advance;
            c_flush = bus.flush;
            c_addr  = bus.mem_req_addr;
            if (q.size() != 0 && bus.inst_ready && !bus.flush) void'(q.pop_front());
            if (bus.mem_resp_valid) begin
                if (!bus.flush && !stale) begin
                    e.data  = data_of(out_addr);
                    e.addr  = out_addr;
                    e.fault = (out_addr == 64'h2000);
                    q.push_back(e);
                    if (e.fault) faulted = 1;
                end
                outstanding = 0;
                stale       = 0;
            end
            if (exp_fault && !bus.flush) begin
                e.data  = '0;
                e.addr  = pc_model;
                e.fault = 1;
                q.push_back(e);
                faulted = 1;
            end
            if (c_hs) begin
                outstanding = 1;
                out_addr    = pc_model;
            end
            if (bus.flush) begin
                q.delete();
                faulted = 0;
                if (outstanding) stale = 1;
            end
        end
    end

    initial begin
        bus.flush         = 0;
        bus.mem_req_ready = 1;
        bus.inst_ready    = 0;
        #1;
        chk_zero("reset");
        tick(2);
        rst_n = 1;
        // first fetch from 0x0 with zero-wait memory
        tick(1);
        chk("t1_req_valid", bus.mem_req_valid, 1);
        chk("t1_req_addr", bus.mem_req_addr, 64'h0);
        chk("t1_pc_adv", bus.pc_advance, 1);
        tick(1);
        chk("t1_pc_adv_pulse", bus.pc_advance, 0);
        chk("t1_not_yet", bus.inst_valid, 0);
        tick(1);
        chk("t1_inst_valid", bus.inst_valid, 1);
        chk("t1_inst_addr", bus.inst_addr, 64'h0);
        chk("t1_inst_data", bus.inst_data, 64'h13);
        chk("t1_inst_fault", bus.inst_fault, 0);
        tick(8);
        chk("t1_full_noreq", bus.mem_req_valid, 0);
        // queue fills to DEPTH from 0x1000 while the decoder stalls
        bus.flush = 1;
        flush_tgt = 64'h1000;
        tick(1);
        bus.flush = 0;
        tick(10);
        chk("t2_noreq", bus.mem_req_valid, 0);
        chk("t2_head", bus.inst_addr, 64'h1000);
        bus.inst_ready = 1;
        tick(1);
        bus.inst_ready = 0;
        chk("t2_second", bus.inst_addr, 64'h1004);
        for (int i = 0; i < 10 && !bus.mem_req_valid; i++) tick(1);
        chk("t2_third_req", bus.mem_req_addr, 64'h1008);
        tick(8);
        // memory stalls the request for three cycles
        bus.mem_req_ready = 0;
        bus.inst_ready    = 1;
        bus.flush         = 1;
        flush_tgt         = 64'h1100;
        tick(1);
        bus.flush = 0;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            chk("t3_req_valid", bus.mem_req_valid, 1);
            chk("t3_req_addr", bus.mem_req_addr, 64'h1100);
            chk("t3_no_adv", bus.pc_advance, 0);
            tick(1);
        end
        bus.mem_req_ready = 1;
        #1;
        chk("t3_adv", bus.pc_advance, 1);
        tick(10);
        // flush while waiting for a slow response that must be discarded
        resp_delay = 3;
        bus.flush  = 1;
        flush_tgt  = 64'h3000;
        tick(1);
        bus.flush = 0;
        for (int i = 0; i < 10 && !bus.pc_advance; i++) tick(1);
        chk("t4_adv", bus.pc_advance, 1);
        chk("t4_req_addr", bus.mem_req_addr, 64'h3000);
        tick(1);
        bus.flush  = 1;
        flush_tgt  = 64'h3100;
        resp_delay = 1;
        tick(1);
        bus.flush = 0;
        chk("t4_drain_a", bus.mem_req_valid, 0);
        tick(1);
        chk("t4_drain_b", bus.mem_req_valid, 0);
        for (int i = 0; i < 10 && !bus.mem_req_valid; i++) tick(1);
        chk("t4_new_addr", bus.mem_req_addr, 64'h3100);
        tick(6);
        // misaligned PC produces a fault entry and parks the stage
        bus.inst_ready = 0;
        tick(10);
        bus.flush = 1;
        flush_tgt = 64'h1002;
        tick(1);
        bus.flush = 0;
        exp_fault = 1;
        tick(1);
        exp_fault = 0;
        chk("t5_valid", bus.inst_valid, 1);
        chk("t5_addr", bus.inst_addr, 64'h1002);
        chk("t5_fault", bus.inst_fault, 1);
        chk("t5_data", bus.inst_data, 0);
        chk("t5_noreq", bus.mem_req_valid, 0);
        chk("t5_no_adv", bus.pc_advance, 0);
        tick(4);
        chk("t5_hold_noreq", bus.mem_req_valid, 0);
        // access error at 0x2000
        bus.flush = 1;
        flush_tgt = 64'h2000;
        tick(1);
        bus.flush = 0;
        for (int i = 0; i < 10 && !bus.inst_valid; i++) tick(1);
        chk("t6_addr", bus.inst_addr, 64'h2000);
        chk("t6_fault", bus.inst_fault, 1);
        chk("t6_data", bus.inst_data, 64'h20000013);
        tick(4);
        chk("t6_stopped", bus.mem_req_valid, 0);
        // asynchronous reset in the middle of a WAIT
        resp_delay = 3;
        bus.flush  = 1;
        flush_tgt  = 64'h4000;
        tick(1);
        bus.flush = 0;
        for (int i = 0; i < 10 && !bus.pc_advance; i++) tick(1);
        chk("t7_adv", bus.pc_advance, 1);
        tick(1);
        #2;
        rst_n = 0;
        #1;
        chk_zero("t7_async");
        tick(2);
        resp_delay = 1;
        rst_n      = 1;
        for (int i = 0; i < 10 && !bus.inst_valid; i++) tick(1);
        chk("t7_refetch_addr", bus.inst_addr, 64'h0);
        chk("t7_refetch_data", bus.inst_data, 64'h13);
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly downstream of program_counter. It consumes the current PC, issues single-outstanding instruction-memory reads and tells the PC when to step. Returned instructions are buffered, tagged with their address and fault status, in a small FIFO feeding the decoder. It also handles branch-redirect flushes, including discarding a stale in-flight response.

Parameters:
WORDSIZE, 64, width of addresses / PC
INSTSIZE, 32, width of one instruction
DEPTH, 2, instruction queue entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_addr  input  WORDSIZE  current PC from program_counter
pc_advance  output  1  one-cycle pulse: PC must step to next instruction
flush  input  1  redirect: discard queue and in-flight fetch (PC reloaded externally same cycle)
mem_req_valid  output  1  read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  WORDSIZE  read address
mem_resp_valid  input  1  read data valid (exactly one per accepted request, >=1 cycle later)
mem_resp_data  input  INSTSIZE  instruction word
mem_resp_error  input  1  access fault for this response
inst_valid  output  1  queue head valid
inst_ready  input  1  decoder accepts head
inst_data  output  INSTSIZE  head instruction
inst_addr  output  WORDSIZE  head instruction address
inst_fault  output  1  head is a fault entry (misaligned or access error)

Behaviour:
- Reset (async, rst_n=0): state IDLE, queue empty, all outputs 0; takes effect immediately even mid-transaction. A response arriving after reset release for a pre-reset request is out of contract.
- FSM states: IDLE, REQ, WAIT, DRAIN, FAULT.
- IDLE: if count<DEPTH and !flush: if pc_addr[1:0]==0, latch pc_addr into req_addr -> REQ; else push fault entry {data=0, addr=pc_addr, fault=1} -> FAULT. Full queue: stay IDLE.
- REQ: mem_req_valid=1, mem_req_addr=req_addr held stable until accepted. On mem_req_ready: pc_advance=1 that cycle -> WAIT. Flush in REQ: request withdrawn -> IDLE, no pc_advance.
- WAIT: on mem_resp_valid push {mem_resp_data, req_addr, mem_resp_error}; error -> FAULT, else -> IDLE. Flush without response -> DRAIN. Flush with response the same cycle -> response dropped -> IDLE.
- DRAIN: wait for mem_resp_valid, discard it -> IDLE. Further flushes keep DRAIN. No new request issued before the stale response returns.
- FAULT: no requests; leaves only on flush -> IDLE.
- Queue: FIFO, inst_* driven from head, inst_valid = (count!=0). Pop when inst_valid && inst_ready. Push and pop in one cycle keeps count.
- Overflow is impossible: a request is only launched when count<DEPTH, and at most one is outstanding.
- Flush priority: the queue is emptied next cycle regardless of push or pop that cycle; inst_valid=0 the cycle after flush.
- Latency (zero-wait memory): pc_addr sampled in IDLE at cycle t; mem_req_valid at t+1; response at t+2; inst_valid at t+3. Peak throughput is one instruction per 3 cycles.
- pc_advance is asserted only on the request handshake, so the PC never advances past a pending fault.

Test Plan:
- Reset then pc_addr=0x0, memory ready always, response next cycle with 0x00000013 -> pc_advance pulse at cycle 2, inst_valid at cycle 4 with inst_addr=0x0, inst_data=0x00000013, inst_fault=0.
- inst_ready=0, PC stepping by 4 from 0x1000 -> exactly 2 entries queued (0x1000, 0x1004); no third mem_req_valid until one pop.
- mem_req_ready held low 3 cycles -> mem_req_addr stable, no pc_advance until the ready cycle.
- Flush while in WAIT, response 2 cycles later (data 0xDEADBEEF) -> response discarded, no inst_valid for it; next request uses the new pc_addr.
- pc_addr=0x1002 -> fault entry with inst_addr=0x1002 and inst_fault=1, no memory request, no pc_advance; FSM holds in FAULT until flush.
- mem_resp_error=1 on the fetch at 0x2000 -> entry fault=1, fetching stops; rst_n pulsed low mid-WAIT -> all outputs 0 immediately.
